// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types and per-stage lane counts.
package cnn_pkg;
  typedef logic [31:0] word_t;

  localparam int LANES_L0 = 4;
  localparam int LANES_L1 = 8;
  localparam int LANES_L2 = 8;
  localparam int LANES_L3 = 8;
  localparam int LANES_L4 = 16;
  localparam int LANES_L5 = 16;
  localparam int LANES_L6 = 16;

  typedef word_t [15:0] vec16_t;
endpackage

// File: rtl/cnn_result_serializer_if.sv
// Word stream from the result serializer toward the host/DMA side.
interface cnn_result_serializer_if #(
    parameter int DW = 32
);
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eof;

    modport master(output m_valid, output m_data, output m_sof, output m_eof, input m_ready);
    modport slave (input m_valid, input m_data, input m_sof, input m_eof, output m_ready);
endinterface

// File: rtl/cnn_result_serializer_vec_fifo.sv
// Register-array vector FIFO; the caller guarantees wr_en is never asserted
// on a full FIFO unless pop is asserted in the same cycle.
module vec_fifo #(
    parameter int W     = 514,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [LW-1:0] level,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; level alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == LW'(DEPTH));
endmodule

// File: rtl/cnn_result_serializer.sv
// Buffers 16-lane result vectors from the pooling stage and replays them one
// word per cycle over a valid/ready stream, flagging dropped vectors.
module cnn_result_serializer
    import cnn_pkg::*;
#(
    parameter int LANES          = LANES_L6,
    parameter int DW             = $bits(word_t),
    parameter int DEPTH          = 4,
    parameter int VECS_PER_FRAME = 1,
    localparam int LVW           = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    input_valid,
    input  logic                    sof,
    input  logic [DW-1:0]           d_in [LANES],
    cnn_result_serializer_if.master m_if,
    output logic [LVW-1:0]          level,
    output logic                    overflow,
    output logic                    frame_err
);
    localparam int W   = LANES * DW + 2;
    localparam int CW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VW  = (VECS_PER_FRAME > 1) ? $clog2(VECS_PER_FRAME) : 1;

    logic [CW-1:0] lane_cnt;
    logic [VW-1:0] vec_cnt;
    logic [VW-1:0] vec_cnt_next;
    logic          eof_flag;
    logic          full;
    logic          wr_en;
    logic          pop;
    logic          xfer;
    logic          last_lane;
    logic          valid;
    logic [W-1:0]  wr_vec;
    logic [W-1:0]  rd_vec;
    logic [DW-1:0] rd_words [LANES];

    assign vec_cnt_next = sof ? '0 : vec_cnt;
    assign eof_flag     = (vec_cnt_next == VW'(VECS_PER_FRAME - 1));
    assign valid        = (level != '0);
    assign last_lane    = (lane_cnt == CW'(LANES - 1));
    assign xfer         = valid & m_if.m_ready;
    assign pop          = xfer & last_lane;
    // A full FIFO can still accept when its head vector leaves this cycle.
    assign wr_en        = input_valid & (~full | pop);

    always_comb begin
        wr_vec = '0;
        wr_vec[W-1] = sof;
        wr_vec[W-2] = eof_flag;
        for (int i = 0; i < LANES; i++) begin
            wr_vec[i*DW +: DW] = d_in[i];
            rd_words[i]        = rd_vec[i*DW +: DW];
        end
    end

    vec_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_vec),
        .pop     (pop),
        .rd_data (rd_vec),
        .level   (level),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt  <= '0;
            vec_cnt   <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (xfer) lane_cnt <= last_lane ? '0 : lane_cnt + 1'b1;
            // The frame position advances even for dropped vectors.
            if (input_valid) vec_cnt <= eof_flag ? '0 : vec_cnt_next + 1'b1;
            if (input_valid && sof && vec_cnt != '0) frame_err <= 1'b1;
            if (input_valid && !wr_en) overflow <= 1'b1;
        end
    end

    assign m_if.m_valid = valid;
    assign m_if.m_data  = valid ? rd_words[lane_cnt] : '0;
    assign m_if.m_sof   = valid & rd_vec[W-1] & (lane_cnt == '0);
    assign m_if.m_eof   = valid & rd_vec[W-2] & last_lane;
endmodule

// File: tb/tb_cnn_result_serializer.sv
// Checks two serializers (VECS_PER_FRAME = 1 and 2) sharing one stimulus
// against a word-queue reference model.
module tb_cnn_result_serializer;
    localparam int LANES = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        s;
        logic        e;
    } wd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_valid;
    logic        sof;
    logic        ready;
    logic [31:0] d_in [LANES];
    logic [2:0]  lvl  [2];
    logic        ovf  [2];
    logic        ferr [2];

    int n_vec = 0;
    int n_err = 0;

    wd_t mq [2][$];
    int  vc    [2];
    bit  movf  [2];
    bit  mferr [2];

    cnn_result_serializer_if #(.DW(32)) if0 ();
    cnn_result_serializer_if #(.DW(32)) if1 ();
    assign if0.m_ready = ready;
    assign if1.m_ready = ready;

    cnn_result_serializer #(.LANES(LANES), .DW(32), .DEPTH(DEPTH), .VECS_PER_FRAME(1)) dut0 (
        .clk(clk), .rst(rst), .input_valid(input_valid), .sof(sof), .d_in(d_in),
        .m_if(if0), .level(lvl[0]), .overflow(ovf[0]), .frame_err(ferr[0])
    );

    cnn_result_serializer #(.LANES(LANES), .DW(32), .DEPTH(DEPTH), .VECS_PER_FRAME(2)) dut1 (
        .clk(clk), .rst(rst), .input_valid(input_valid), .sof(sof), .d_in(d_in),
        .m_if(if1), .level(lvl[1]), .overflow(ovf[1]), .frame_err(ferr[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the model, then advance the model over one edge.
    task automatic step();
        int  sz, lvl_m, vn;
        bit  pop_w, pop_v, eof;
        wd_t hd;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            sz = mq[m].size();
            hd = (sz != 0) ? mq[m][0] : '0;
            chk($sformatf("dut%0d.m_valid", m), m ? if1.m_valid : if0.m_valid, 32'(sz != 0));
            chk($sformatf("dut%0d.m_data", m),  m ? if1.m_data  : if0.m_data,  hd.d);
            chk($sformatf("dut%0d.m_sof", m),   m ? if1.m_sof   : if0.m_sof,   32'(hd.s));
            chk($sformatf("dut%0d.m_eof", m),   m ? if1.m_eof   : if0.m_eof,   32'(hd.e));
            chk($sformatf("dut%0d.level", m),   lvl[m],  32'((sz + LANES - 1) / LANES));
            chk($sformatf("dut%0d.overflow", m),  ovf[m],  32'(movf[m]));
            chk($sformatf("dut%0d.frame_err", m), ferr[m], 32'(mferr[m]));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                mq[m].delete();
                vc[m] = 0; movf[m] = 0; mferr[m] = 0;
            end else begin
                sz    = mq[m].size();
                lvl_m = (sz + LANES - 1) / LANES;
                pop_w = ready && sz != 0;
                pop_v = pop_w && (sz % LANES == 1);
                if (pop_w) void'(mq[m].pop_front());
                if (input_valid) begin
                    vn = sof ? 0 : vc[m];
                    if (sof && vc[m] != 0) mferr[m] = 1;
                    eof   = (vn == m);        // frame length is m+1 vectors
                    vc[m] = eof ? 0 : vn + 1;
                    if (lvl_m < DEPTH || pop_v) begin
                        for (int i = 0; i < LANES; i++)
                            mq[m].push_back('{d: d_in[i], s: sof && i == 0, e: eof && i == LANES - 1});
                    end else begin
                        movf[m] = 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic send(input bit sof_v);
        for (int i = 0; i < LANES; i++) d_in[i] = $urandom;
        sof = sof_v;
        input_valid = 1'b1;
        step();
        input_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; input_valid = 1'b0; sof = 1'b0; ready = 1'b0;
        for (int i = 0; i < LANES; i++) d_in[i] = '0;
        for (int m = 0; m < 2; m++) begin vc[m] = 0; movf[m] = 0; mferr[m] = 0; end
        @(posedge clk); #1;
        do_reset();
        step();

        // Single vector, full-rate drain.
        ready = 1'b1;
        for (int i = 0; i < LANES; i++) d_in[i] = 32'h100 + 32'(i);
        sof = 1'b1; input_valid = 1'b1;
        step();
        input_valid = 1'b0; sof = 1'b0;
        repeat (17) step();

        // Backpressure pattern 1,0,0,1,0,0...
        send(1'b1);
        for (int k = 0; k < 50; k++) begin
            ready = (k % 3 == 0);
            step();
        end
        ready = 1'b1;
        repeat (4) step();

        // Overflow: five vectors into a four-deep FIFO with no drain.
        ready = 1'b0;
        repeat (5) send(1'b1);
        repeat (2) step();
        ready = 1'b1;
        repeat (70) step();

        // Write lands on the cycle the head vector's last lane leaves.
        do_reset();
        ready = 1'b0;
        repeat (4) send(1'b1);
        ready = 1'b1;
        repeat (15) step();
        send(1'b1);
        repeat (70) step();

        // Frame flags: A(sof) B C(sof) D(sof).
        do_reset();
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        repeat (70) step();

        // Reset mid-drain at word 7 with two vectors buffered.
        ready = 1'b0;
        send(1'b1); send(1'b0);
        ready = 1'b1;
        repeat (7) step();
        do_reset();
        step();
        send(1'b1);
        repeat (18) step();

        // Random traffic.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < LANES; i++) d_in[i] = $urandom;
            input_valid = ($urandom_range(0, 5) == 0);
            sof         = ($urandom_range(0, 2) == 0);
            ready       = ($urandom_range(0, 3) != 0);
            step();
        end
        input_valid = 1'b0; sof = 1'b0; ready = 1'b1;
        repeat (80) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
